dot_accumulator: RTL and testbench

- Downstream consumer of the 64-bit signed product produced by the 32x32 signed multiplier.
- Accumulates a stream of signed products into a wide accumulator and emits one sum per group of beats; the group is terminated by an in_last tag.
- Forms the accumulate half of a multiply-accumulate / dot-product path.
- Valid/ready handshakes on both the input and the output.

---
 rtl/dot_accumulator.sv | 133 +++++++++++++
 tb/tb_dot_accumulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums a stream of signed products into a wide accumulator
// and presents one result per group, where a group ends on a beat tagged in_last.
// Optional feature macro: DOT_ACC_SAT_EN. When it is defined, an overflowing
// beat clamps the accumulator to the signed extreme. When it is undefined,
// the accumulator wraps. Overflow is flagged in both builds.
module dot_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             oovf_q, oovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_raw;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_beat;
  logic             ovf_next;

  // Sign-extend the product. Replication is only legal when the widths differ.
  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    end else begin : g_same
      assign prod_ext = in_prod;
    end
  endgenerate

  assign acc_raw  = acc_q + prod_ext;
  // Overflow: both operands have the same sign, but the raw sum has a different sign.
  assign ovf_beat = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (acc_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef DOT_ACC_SAT_EN
  assign acc_next = ovf_beat ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : acc_raw;
`else
  assign acc_next = acc_raw;
`endif
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign ovf_next = ovf_q | ovf_beat;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = oovf_q;

  // Next state: accumulate accepted beats, latch the result on the last beat,
  // and release the result when it is taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    count_d = count_q;
    oovf_d  = oovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          ovf_d = ovf_next;
          if (in_last) begin
            sum_d   = acc_next;
            count_d = cnt_inc;
            oovf_d  = ovf_next;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers. rst and clr both return every register to its reset value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

// File: tb/tb_dot_accumulator.sv
// Testbench for dot_accumulator. It drives directed product groups and checks
// the outputs every cycle against a behavioural model that tracks the exact
// running sum. Hand-computed expectations pin the model's results.
module tb_dot_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // Main DUT uses the default widths (ACC_W = 72).
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_prod   = '0;
  logic        in_ready;
  logic        out_valid;
  logic [71:0] out_sum;
  logic [15:0] out_count;
  logic        out_ovf;

  // Second DUT uses ACC_W = 64, so the accumulator can overflow on the second beat.
  logic        b_valid = 1'b0;
  logic        b_last  = 1'b0;
  logic        b_ready = 1'b0;
  logic [63:0] b_prod  = '0;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [63:0] b_sum;
  logic [15:0] b_count;
  logic        b_ovf;

  dot_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  dot_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(b_valid), .in_ready(b_in_ready), .in_prod(b_prod), .in_last(b_last),
    .out_valid(b_out_valid), .out_ready(b_ready),
    .out_sum(b_sum), .out_count(b_count), .out_ovf(b_ovf)
  );

  int checks   = 0;
  int failures = 0;

  // The model keeps the exact running sum in 80 bits. Overflow is a range test on that sum.
  localparam logic signed [79:0] MAXV = (80'sd1 <<< 71) - 80'sd1;
  localparam logic signed [79:0] MINV = -(80'sd1 <<< 71);

  logic        m_hold  = 1'b0;
  logic [71:0] m_acc   = '0;
  logic [71:0] m_sum   = '0;
  int          m_cnt   = 0;
  int          m_count = 0;
  logic        m_ovf   = 1'b0;
  logic        m_oovf  = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic signed [79:0] a;
    logic signed [79:0] p;
    logic signed [79:0] ex;
    if (rst || clr) begin
      m_hold = 1'b0; m_acc = '0; m_cnt = 0; m_ovf = 1'b0;
      m_sum = '0; m_count = 0; m_oovf = 1'b0;
    end else if (!m_hold && in_valid) begin
      a  = $signed(m_acc);
      p  = $signed(in_prod);
      ex = a + p;
      if (ex > MAXV || ex < MINV) begin
        m_ovf = 1'b1;
`ifdef DOT_ACC_SAT_EN
        m_acc = (ex > MAXV) ? MAXV[71:0] : MINV[71:0];
`else
        m_acc = ex[71:0];
`endif
      end else begin
        m_acc = ex[71:0];
      end
      if (m_cnt < 65535) m_cnt++;
      if (in_last) begin
        m_sum = m_acc; m_count = m_cnt; m_oovf = m_ovf; m_hold = 1'b1;
      end
    end else if (m_hold && out_ready) begin
      m_acc = '0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
    end
  endtask

  task automatic compare_model();
    check("m_in_ready", 72'(in_ready), 72'(!m_hold));
    check("m_out_valid", 72'(out_valid), 72'(m_hold));
    if (m_hold) begin
      check("m_out_sum", out_sum, m_sum);
      check("m_out_count", 72'(out_count), 72'(m_count));
      check("m_out_ovf", 72'(out_ovf), 72'(m_oovf));
    end
  endtask

  // One clock: the model sees the same inputs as the DUT at the rising edge,
  // and the outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic beat(input logic [63:0] p, input logic last);
    in_valid = 1'b1; in_prod = p; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic expect_idle_zero(input string tag);
    check({tag, "_out_valid"}, 72'(out_valid), 72'd0);
    check({tag, "_in_ready"}, 72'(in_ready), 72'd1);
    check({tag, "_out_sum"}, out_sum, 72'd0);
    check({tag, "_out_count"}, 72'(out_count), 72'd0);
    check({tag, "_out_ovf"}, 72'(out_ovf), 72'd0);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    expect_idle_zero("reset");

    // Basic group: 6 - 20 + 100 = 86.
    beat(64'd6, 1'b0);
    beat(64'(-20), 1'b0);
    beat(64'd100, 1'b1);
    check("grp1_out_valid", 72'(out_valid), 72'd1);
    check("grp1_in_ready", 72'(in_ready), 72'd0);
    check("grp1_out_sum", out_sum, 72'd86);
    check("grp1_out_count", 72'(out_count), 72'd3);
    check("grp1_out_ovf", 72'(out_ovf), 72'd0);

    // Backpressure: the result must stay stable, and inputs must be ignored.
    in_valid = 1'b1; in_prod = 64'd999; in_last = 1'b1;
    repeat (5) tick();
    check("hold_out_sum", out_sum, 72'd86);
    check("hold_out_count", 72'(out_count), 72'd3);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    check("taken_in_ready", 72'(in_ready), 72'd1);
    check("taken_out_valid", 72'(out_valid), 72'd0);
    beat(64'd10, 1'b1);
    check("fresh_out_sum", out_sum, 72'd10);
    check("fresh_out_count", 72'(out_count), 72'd1);
    take();

    // Single beat carrying the most negative product: must be sign-extended.
    beat(64'h8000_0000_0000_0000, 1'b1);
    check("minprod_out_sum", out_sum, 72'hFF_8000_0000_0000_0000);
    check("minprod_out_count", 72'(out_count), 72'd1);
    check("minprod_out_ovf", 72'(out_ovf), 72'd0);
    take();

    // clr arrives together with the last beat: the partial sum and that beat are discarded.
    beat(64'd5, 1'b0);
    beat(64'd5, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_prod = 64'd5; in_last = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clr_out_valid", 72'(out_valid), 72'd0);
    check("clr_in_ready", 72'(in_ready), 72'd1);
    beat(64'd7, 1'b1);
    check("postclr_out_sum", out_sum, 72'd7);
    check("postclr_out_count", 72'(out_count), 72'd1);
    take();

    // 260 maximum positive products overflow the 72-bit accumulator on beat 257.
    repeat (259) beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check("big_out_count", 72'(out_count), 72'd260);
    check("big_out_ovf", 72'(out_ovf), 72'd1);
`ifdef DOT_ACC_SAT_EN
    check("big_out_sum", out_sum, 72'h7F_FFFF_FFFF_FFFF_FFFF);
`else
    check("big_out_sum", out_sum, 72'h81_FFFF_FFFF_FFFF_FEFC);
`endif
    take();

    // Mixed signs and extreme values: only the model checks this group.
    beat(64'(-3), 1'b0);
    beat(64'h8000_0000_0000_0000, 1'b0);
    beat(64'd12, 1'b0);
    beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    take();

    // 64-bit accumulator: MAX + 1 overflows.
    b_valid = 1'b1; b_prod = 64'h7FFF_FFFF_FFFF_FFFF; b_last = 1'b0;
    tick();
    b_prod = 64'd1; b_last = 1'b1;
    tick();
    b_valid = 1'b0; b_last = 1'b0;
    check("w64_out_valid", 72'(b_out_valid), 72'd1);
    check("w64_out_ovf", 72'(b_ovf), 72'd1);
    check("w64_out_count", 72'(b_count), 72'd2);
`ifdef DOT_ACC_SAT_EN
    check("w64_out_sum", 72'(b_sum), 72'h7FFF_FFFF_FFFF_FFFF);
`else
    check("w64_out_sum", 72'(b_sum), 72'h8000_0000_0000_0000);
`endif
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("w64_taken_in_ready", 72'(b_in_ready), 72'd1);

    // rst while a result is pending, then rst and clr together.
    beat(64'd3, 1'b1);
    check("prerst_out_valid", 72'(out_valid), 72'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle_zero("rst_hold");
    beat(64'd3, 1'b1);
    check("prerstclr_out_valid", 72'(out_valid), 72'd1);
    rst = 1'b1; clr = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0;
    expect_idle_zero("rstclr_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
